// File: rtl/fde_pkg.sv
// Shared types and constants for the fetch stage: sequencer states, the
// instruction width and the field layout of the IF/ID pipeline register.
package fde_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      LOAD  = 2'd3
   } fetch_state_t;

   localparam int INSTR_W = 32;

   localparam int IFID_W        = 2 * INSTR_W;
   localparam int IFID_PC_HI    = 63;
   localparam int IFID_PC_LO    = 32;
   localparam int IFID_INSTR_HI = 31;
   localparam int IFID_INSTR_LO = 0;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding register that catches an instruction returning from
// memory while decode is stalled, so the read is never lost or repeated.
module fetch_skid_buf
   import fde_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              load,
   input  logic              clear,
   input  logic [IFID_W-1:0] din,
   output logic              valid,
   output logic [IFID_W-1:0] dout
);

   // Clear wins over load so a flush always empties the entry.
   always_ff @(posedge clock) begin
      if (!reset) begin
         valid <= 1'b0;
         dout  <= '0;
      end else if (clear) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         dout  <= din;
      end
   end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch stage controller: owns the PC, issues reads to a 1-cycle-latency
// instruction memory, builds the IF/ID register, and hands the memory port
// to the program loader once any outstanding read has landed.
module fetch_sequencer
   import fde_pkg::*;
#(
   parameter int          ADDR_W   = 7,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              stall,
   input  logic              redirect,
   input  logic [31:0]       redirect_pc,
   input  logic              ld_req,
   output logic              ld_gnt,
   input  logic              ld_we,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [31:0]       ld_data,
   output logic              imem_rd,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   input  logic [31:0]       imem_rdata,
   output logic [63:0]       if_id,
   output logic              if_id_valid,
   output logic [31:0]       pc
);

   fetch_state_t        state_q;
   fetch_state_t        state_d;
   fetch_state_t        ret_q;
   fetch_state_t        ret_d;
   logic                issue;
   logic                inflight;
   logic [INSTR_W-1:0]  inflight_pc;
   logic                redirect_ok;
   logic                skid_valid;
   logic [IFID_W-1:0]   skid_data;
   logic                skid_load;
   logic                skid_clear;

   // A redirect is ignored while idle; everywhere else it flushes.
   assign redirect_ok = redirect && (state_q != IDLE);

   // Stalled returns go to the skid; a flush or a delivery empties it.
   assign skid_load  = !redirect_ok && stall && inflight;
   assign skid_clear = redirect_ok || (!stall && skid_valid);

   fetch_skid_buf u_skid (
      .clock (clock),
      .reset (reset),
      .load  (skid_load),
      .clear (skid_clear),
      .din   ({inflight_pc, imem_rdata}),
      .valid (skid_valid),
      .dout  (skid_data)
   );

   // Next-state and memory-port steering; all strobes are forced low in reset.
   always_comb begin
      state_d    = state_q;
      ret_d      = ret_q;
      issue      = 1'b0;
      ld_gnt     = 1'b0;
      imem_we    = 1'b0;
      imem_addr  = pc[ADDR_W-1:0];
      imem_wdata = '0;
      case (state_q)
         IDLE: begin
            if (ld_req) begin
               state_d = LOAD;
               ret_d   = IDLE;
            end else if (start) begin
               state_d = RUN;
            end
         end
         RUN: begin
            issue = !stall && !redirect && !ld_req && !skid_valid;
            if (ld_req) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (!inflight) begin
               state_d = LOAD;
               ret_d   = RUN;
            end
         end
         LOAD: begin
            ld_gnt     = 1'b1;
            imem_we    = ld_we;
            imem_addr  = ld_addr;
            imem_wdata = ld_data;
            if (!ld_req) begin
               state_d = ret_q;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (!reset) begin
         issue   = 1'b0;
         ld_gnt  = 1'b0;
         imem_we = 1'b0;
      end
      imem_rd = issue;
   end

   // State, PC and outstanding-read tracking; a redirect drops the read.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q     <= IDLE;
         ret_q       <= IDLE;
         pc          <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= '0;
      end else begin
         state_q <= state_d;
         ret_q   <= ret_d;
         if (redirect_ok) begin
            pc       <= redirect_pc;
            inflight <= 1'b0;
         end else if (issue) begin
            pc          <= pc + 32'd1;
            inflight    <= 1'b1;
            inflight_pc <= pc;
         end else begin
            inflight <= 1'b0;
         end
      end
   end

   // IF/ID register: flush, hold on stall, then skid before fresh data.
   always_ff @(posedge clock) begin
      if (!reset) begin
         if_id       <= '0;
         if_id_valid <= 1'b0;
      end else if (redirect_ok) begin
         if_id_valid <= 1'b0;
      end else if (stall) begin
         if_id_valid <= if_id_valid;
      end else if (skid_valid) begin
         if_id       <= skid_data;
         if_id_valid <= 1'b1;
      end else if (inflight) begin
         if_id[IFID_PC_HI:IFID_PC_LO]       <= inflight_pc;
         if_id[IFID_INSTR_HI:IFID_INSTR_LO] <= imem_rdata;
         if_id_valid                        <= 1'b1;
      end else begin
         if_id_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: a per-edge vector table drives the main flow
// (stream, stall/skid, redirect, loader handoff) while a queue of expected
// IF/ID words checks every delivered instruction in order. Hand-written
// sequences cover mid-run reset and PC/address wrap with RESET_PC=0x7F.
module tb_fetch_sequencer;

   typedef struct {
      logic        start;
      logic        stall;
      logic        redirect;
      logic [31:0] rpc;
      logic        ldreq;
      logic        ldwe;
      logic [6:0]  ldaddr;
      logic [31:0] lddata;
      logic        push;
      logic [31:0] push_pc;
      logic        exp_valid;
      logic        exp_gnt;
      logic [31:0] exp_pc;
      logic        chk_ifid;
      logic [63:0] exp_ifid;
   } vec_t;

   logic        clock;
   logic        reset;
   logic        preload;
   logic        start;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        ld_req;
   logic        ld_gnt;
   logic        ld_we;
   logic [6:0]  ld_addr;
   logic [31:0] ld_data;
   logic        imem_rd;
   logic        imem_we;
   logic [6:0]  imem_addr;
   logic [31:0] imem_wdata;
   logic [31:0] imem_rdata;
   logic [63:0] if_id;
   logic        if_id_valid;
   logic [31:0] pc;

   logic        start_b;
   logic        zero_bit;
   logic [31:0] zero_word;
   logic [6:0]  zero_addr;
   logic        ld_gnt_b;
   logic        imem_rd_b;
   logic        imem_we_b;
   logic [6:0]  imem_addr_b;
   logic [31:0] imem_wdata_b;
   logic [31:0] imem_rdata_b;
   logic [63:0] if_id_b;
   logic        if_id_valid_b;
   logic [31:0] pc_b;

   logic [31:0] mem_a [128];
   logic [31:0] mem_b [128];
   logic [31:0] gold  [128];
   logic [63:0] exp_q [$];
   vec_t        vecs  [$];

   int checks;
   int failures;

   fetch_sequencer #(.ADDR_W(7), .RESET_PC(32'h0)) dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .ld_req      (ld_req),
      .ld_gnt      (ld_gnt),
      .ld_we       (ld_we),
      .ld_addr     (ld_addr),
      .ld_data     (ld_data),
      .imem_rd     (imem_rd),
      .imem_we     (imem_we),
      .imem_addr   (imem_addr),
      .imem_wdata  (imem_wdata),
      .imem_rdata  (imem_rdata),
      .if_id       (if_id),
      .if_id_valid (if_id_valid),
      .pc          (pc)
   );

   fetch_sequencer #(.ADDR_W(7), .RESET_PC(32'h7F)) dut_b (
      .clock       (clock),
      .reset       (reset),
      .start       (start_b),
      .stall       (zero_bit),
      .redirect    (zero_bit),
      .redirect_pc (zero_word),
      .ld_req      (zero_bit),
      .ld_gnt      (ld_gnt_b),
      .ld_we       (zero_bit),
      .ld_addr     (zero_addr),
      .ld_data     (zero_word),
      .imem_rd     (imem_rd_b),
      .imem_we     (imem_we_b),
      .imem_addr   (imem_addr_b),
      .imem_wdata  (imem_wdata_b),
      .imem_rdata  (imem_rdata_b),
      .if_id       (if_id_b),
      .if_id_valid (if_id_valid_b),
      .pc          (pc_b)
   );

   function automatic logic [31:0] init_a(input int i);
      case (i)
         0:       return 32'h0AAAAAAA;
         1:       return 32'h0BBBBBBB;
         2:       return 32'h0CCCCCCC;
         3:       return 32'h0DDDDDDD;
         4:       return 32'h0FFFFFFF;
         default: return 32'hC0DE0000 | 32'(i);
      endcase
   endfunction

   function automatic logic [31:0] init_b(input int i);
      return 32'hB0000000 | 32'(i);
   endfunction

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Synchronous-read memory models, preloaded while the bench holds preload.
   always @(posedge clock) begin
      if (preload) begin
         for (int i = 0; i < 128; i++) begin
            mem_a[i] <= init_a(i);
            mem_b[i] <= init_b(i);
         end
      end else begin
         if (imem_we)   mem_a[imem_addr]   <= imem_wdata;
         if (imem_rd)   imem_rdata         <= mem_a[imem_addr];
         if (imem_we_b) mem_b[imem_addr_b] <= imem_wdata_b;
         if (imem_rd_b) imem_rdata_b       <= mem_b[imem_addr_b];
      end
   end

   function automatic vec_t vec(input logic st, input logic sl, input logic rd,
                                input logic [31:0] rpc, input logic lr, input logic lw,
                                input logic [6:0] la, input logic [31:0] ldat,
                                input logic pu, input logic [31:0] ppc,
                                input logic ev, input logic eg, input logic [31:0] epc);
      vec_t v;
      v.start = st; v.stall = sl; v.redirect = rd; v.rpc = rpc;
      v.ldreq = lr; v.ldwe = lw; v.ldaddr = la; v.lddata = ldat;
      v.push = pu; v.push_pc = ppc;
      v.exp_valid = ev; v.exp_gnt = eg; v.exp_pc = epc;
      v.chk_ifid = 1'b0; v.exp_ifid = '0;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic applyStimulus(input vec_t v, input int idx);
      start       = v.start;
      stall       = v.stall;
      redirect    = v.redirect;
      redirect_pc = v.rpc;
      ld_req      = v.ldreq;
      ld_we       = v.ldwe;
      ld_addr     = v.ldaddr;
      ld_data     = v.lddata;
      if (v.ldreq && v.ldwe) gold[v.ldaddr] = v.lddata;
      if (v.push) exp_q.push_back({v.push_pc, gold[v.push_pc[6:0]]});
      @(posedge clock);
      #1;
      checkOutput($sformatf("row%0d_valid", idx), 64'(if_id_valid), 64'(v.exp_valid));
      checkOutput($sformatf("row%0d_pc", idx), 64'(pc), 64'(v.exp_pc));
      checkOutput($sformatf("row%0d_gnt", idx), 64'(ld_gnt), 64'(v.exp_gnt));
      if (v.chk_ifid) checkOutput($sformatf("row%0d_hold", idx), if_id, v.exp_ifid);
      if (!v.stall && if_id_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL row%0d_sb_unexpected actual=%h required=none", idx, if_id);
         end else begin
            checkOutput($sformatf("row%0d_sb", idx), if_id, exp_q.pop_front());
         end
      end
   endtask

   initial begin
      vec_t hv;
      checks = 0; failures = 0;
      zero_bit = 1'b0; zero_word = '0; zero_addr = '0;
      for (int i = 0; i < 128; i++) gold[i] = init_a(i);
      reset = 1'b0; preload = 1'b1; start = 1'b0; start_b = 1'b0;
      stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
      ld_req = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_data = '0;
      @(posedge clock); #1;
      preload = 1'b0;
      @(posedge clock); #1;
      $display("[TB] reset phase");
      checkOutput("reset_valid", 64'(if_id_valid), 64'd0);
      checkOutput("reset_if_id", if_id, 64'd0);
      checkOutput("reset_pc", 64'(pc), 64'd0);
      checkOutput("reset_gnt", 64'(ld_gnt), 64'd0);
      checkOutput("reset_pc_b", 64'(pc_b), 64'h7F);
      reset = 1'b1;

      //               st sl rd rpc     lr lw la    ldat          pu ppc     ev eg epc
      vecs.push_back(vec(1, 0, 0, 32'h0,  0, 0, 7'd0, 32'h0,        0, 32'h0,  0, 0, 32'h0));
      vecs.push_back(vec(0, 0, 0, 32'h0,  0, 0, 7'd0, 32'h0,        0, 32'h0,  0, 0, 32'h1));
      vecs.push_back(vec(0, 0, 0, 32'h0,  0, 0, 7'd0, 32'h0,        1, 32'h0,  1, 0, 32'h2));
      vecs.push_back(vec(0, 0, 0, 32'h0,  0, 0, 7'd0, 32'h0,        1, 32'h1,  1, 0, 32'h3));
      vecs.push_back(vec(0, 0, 0, 32'h0,  0, 0, 7'd0, 32'h0,        1, 32'h2,  1, 0, 32'h4));
      for (int k = 0; k < 3; k++) begin
         hv = vec(0, 1, 0, 32'h0, 0, 0, 7'd0, 32'h0, 0, 32'h0, 1, 0, 32'h4);
         hv.chk_ifid = 1'b1;
         hv.exp_ifid = {32'h2, 32'h0CCCCCCC};
         vecs.push_back(hv);
      end
      vecs.push_back(vec(0, 0, 0, 32'h0,  0, 0, 7'd0, 32'h0,        1, 32'h3,  1, 0, 32'h4));
      vecs.push_back(vec(0, 0, 0, 32'h0,  0, 0, 7'd0, 32'h0,        0, 32'h0,  0, 0, 32'h5));
      vecs.push_back(vec(0, 0, 0, 32'h0,  0, 0, 7'd0, 32'h0,        1, 32'h4,  1, 0, 32'h6));
      vecs.push_back(vec(0, 0, 1, 32'h10, 0, 0, 7'd0, 32'h0,        0, 32'h0,  0, 0, 32'h10));
      vecs.push_back(vec(0, 0, 0, 32'h0,  0, 0, 7'd0, 32'h0,        0, 32'h0,  0, 0, 32'h11));
      vecs.push_back(vec(0, 0, 0, 32'h0,  0, 0, 7'd0, 32'h0,        1, 32'h10, 1, 0, 32'h12));
      vecs.push_back(vec(0, 0, 0, 32'h0,  1, 0, 7'd0, 32'h0,        1, 32'h11, 1, 0, 32'h12));
      vecs.push_back(vec(0, 0, 0, 32'h0,  1, 0, 7'd0, 32'h0,        0, 32'h0,  0, 1, 32'h12));
      vecs.push_back(vec(0, 0, 0, 32'h0,  1, 1, 7'd5, 32'h12345678, 0, 32'h0,  0, 1, 32'h12));
      vecs.push_back(vec(0, 0, 0, 32'h0,  0, 0, 7'd0, 32'h0,        0, 32'h0,  0, 0, 32'h12));
      vecs.push_back(vec(0, 0, 0, 32'h0,  0, 0, 7'd0, 32'h0,        0, 32'h0,  0, 0, 32'h13));
      vecs.push_back(vec(0, 0, 0, 32'h0,  0, 0, 7'd0, 32'h0,        1, 32'h12, 1, 0, 32'h14));
      vecs.push_back(vec(0, 0, 1, 32'h5,  0, 0, 7'd0, 32'h0,        0, 32'h0,  0, 0, 32'h5));
      vecs.push_back(vec(0, 0, 0, 32'h0,  0, 0, 7'd0, 32'h0,        0, 32'h0,  0, 0, 32'h6));
      vecs.push_back(vec(0, 0, 0, 32'h0,  0, 0, 7'd0, 32'h0,        1, 32'h5,  1, 0, 32'h7));
      vecs.push_back(vec(0, 0, 0, 32'h0,  0, 0, 7'd0, 32'h0,        1, 32'h6,  1, 0, 32'h8));

      $display("[TB] vector table: %0d rows", vecs.size());
      for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], i);
      checkOutput("sb_drained", 64'(exp_q.size()), 64'd0);

      $display("[TB] mid-run reset with stall high");
      stall = 1'b1;
      reset = 1'b0;
      #1;
      checkOutput("rst_rd_low", 64'(imem_rd), 64'd0);
      @(posedge clock); #1;
      checkOutput("rst_valid", 64'(if_id_valid), 64'd0);
      checkOutput("rst_if_id", if_id, 64'd0);
      checkOutput("rst_pc", 64'(pc), 64'd0);
      checkOutput("rst_gnt", 64'(ld_gnt), 64'd0);
      reset = 1'b1;
      stall = 1'b0;
      for (int k = 0; k < 4; k++) begin
         checkOutput($sformatf("idle%0d_rd", k), 64'(imem_rd), 64'd0);
         @(posedge clock); #1;
         checkOutput($sformatf("idle%0d_valid", k), 64'(if_id_valid), 64'd0);
         checkOutput($sformatf("idle%0d_pc", k), 64'(pc), 64'd0);
      end
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      checkOutput("restart_rd", 64'(imem_rd), 64'd1);
      checkOutput("restart_addr", 64'(imem_addr), 64'd0);

      $display("[TB] wrap from RESET_PC=0x7F");
      start_b = 1'b1;
      @(posedge clock); #1;
      start_b = 1'b0;
      checkOutput("wrap_rd0", 64'(imem_rd_b), 64'd1);
      checkOutput("wrap_addr0", 64'(imem_addr_b), 64'h7F);
      @(posedge clock); #1;
      checkOutput("wrap_addr1", 64'(imem_addr_b), 64'h00);
      checkOutput("wrap_pc1", 64'(pc_b), 64'h80);
      checkOutput("wrap_valid1", 64'(if_id_valid_b), 64'd0);
      @(posedge clock); #1;
      checkOutput("wrap_valid2", 64'(if_id_valid_b), 64'd1);
      checkOutput("wrap_if_id2", if_id_b, {32'h7F, 32'hB000007F});
      @(posedge clock); #1;
      checkOutput("wrap_if_id3", if_id_b, {32'h80, 32'hB0000000});
      checkOutput("wrap_gnt", 64'(ld_gnt_b), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Controls the fetch stage. Owns the PC and sequences reads from a synchronous-read instruction memory (1-cycle latency).
- Produces the 64-bit IF_ID pipeline register as {pc[31:0], instr[31:0]}.
- Handles decode stall, execute redirect (branch/flush), and arbitration of the single instruction-memory port between fetch and a program loader.

Parameters:
- ADDR_W, 7, instruction memory word-address width (128 words).
- RESET_PC, 32'h0, PC value after reset.

Ports:
- clock  in  1  clock
- reset  in  1  reset: synchronous, active-low
- start  in  1  pulse; IDLE -> RUN
- stall  in  1  decode cannot accept; hold if_id
- redirect  in  1  flush and load new PC
- redirect_pc  in  32  target PC
- ld_req  in  1  loader requests memory port
- ld_gnt  out  1  loader owns memory port
- ld_we  in  1  loader write strobe (valid only with ld_gnt)
- ld_addr  in  ADDR_W  loader write address
- ld_data  in  32  loader write data
- imem_rd  out  1  read strobe
- imem_we  out  1  write strobe
- imem_addr  out  ADDR_W  memory address
- imem_wdata  out  32  memory write data
- imem_rdata  in  32  read data, valid the cycle after imem_rd
- if_id  out  64  {pc, instr}
- if_id_valid  out  1  if_id holds a live instruction
- pc  out  32  next fetch PC

Behaviour:
- Reset is sampled only on a clock edge with reset==0. It forces:
  - state=IDLE, pc=RESET_PC
  - if_id=0, if_id_valid=0
  - skid and in-flight flags cleared, ld_gnt=0
- All strobes are deasserted during reset. Reset mid-operation discards everything, including in-flight data.
- States are IDLE, RUN, DRAIN, LOAD.
  - IDLE:
    - ld_req -> LOAD, with return state IDLE.
    - Otherwise start -> RUN.
    - ld_req has priority over start.
  - RUN:
    - issue = !stall && !redirect && !ld_req && !skid_valid.
    - On issue: imem_rd=1, imem_addr=pc[ADDR_W-1:0], pc<=pc+1, inflight<=1, inflight_pc<=pc.
    - ld_req -> DRAIN.
  - DRAIN:
    - No issue.
    - When inflight==0 and skid has been delivered or held -> LOAD, with return state RUN.
  - LOAD:
    - ld_gnt=1. imem_we=ld_we, imem_addr=ld_addr, imem_wdata=ld_data. imem_rd=0.
    - ld_req low -> return state. ld_gnt drops the same edge.
- if_id update at each edge, all states:
  - redirect: pc<=redirect_pc, if_id_valid<=0, inflight and skid discarded. Redirect has priority over stall and is honoured in any non-IDLE state.
  - Else if stall: if_id and if_id_valid held. Returning in-flight data goes to the one-entry skid as {inflight_pc, imem_rdata}.
  - Else if skid_valid: if_id<=skid, valid<=1, skid cleared.
  - Else if inflight: if_id<={inflight_pc, imem_rdata}, valid<=1.
  - Else: valid<=0 and if_id data is held.
  - inflight clears whenever data returns.
- Invariant: skid_valid and inflight are never both set.
- Throughput and latency:
  - 1 instr/cycle with no stall.
  - start at edge 0 gives the first valid if_id at edge 2.
  - Redirect costs 2 bubble cycles.
  - A stall release with skid costs 1 bubble.
- Width rules:
  - pc is 32-bit and wraps modulo 2^32.
  - imem_addr is pc truncated to ADDR_W, so it wraps modulo 2^ADDR_W.
  - The if_id PC field carries the full 32-bit pc.
- Unknown or illegal state -> IDLE.

Decomposition:
- fde_pkg holds:
  - state enum {IDLE, RUN, DRAIN, LOAD}
  - INSTR_W=32
  - IF_ID field bounds: PC at 63:32, INSTR at 31:0
- One sub-module: fetch_skid_buf, a one-entry 64-bit holding register with valid, load and clear.

Test Plan:
- Preload mem[0..4] with 0AAAAAAA, 0BBBBBBB, 0CCCCCCC, 0DDDDDDD, 0FFFFFFF; release reset; start at edge 0.
  - Required: if_id = 00000000_0AAAAAAA at edge 2, then 00000001_0BBBBBBB, and so on, one per cycle.
- Assert stall for 3 cycles while a read is in flight.
  - Required: if_id held.
  - Required: skid captures the next instruction.
  - Required: after release, if_id steps through the PCs with none dropped or duplicated, with one bubble.
- Assert redirect with redirect_pc=0x10 while a read is in flight.
  - Required: the in-flight instruction never appears.
  - Required: valid is low for 2 edges, then if_id = 00000010_{mem[16]}.
- Assert ld_req in RUN with a read in flight.
  - Required: that instruction is delivered.
  - Required: ld_gnt rises after the drain.
  - Write mem[5]=12345678, then drop ld_req.
  - Required: fetch resumes at the saved pc with no skipped PCs.
- Pull reset low mid-RUN with stall high.
  - Required: next edge gives IDLE, if_id=0, valid=0, pc=0.
  - Required: no imem_rd until the next start.
- Set RESET_PC=0x7F and start.
  - Required: imem_addr goes 7F, 00.
  - Required: if_id PC fields are 0000007F, then 00000080.
